// File: rtl/skstat_gen_reg.sv
// -----------------------------------------------------------------------------
// skstat_gen_reg
// Parametrised SKSTAT-style status register. Holds NEVT sticky event flags
// (edge- or level-triggered per bit), NLIVE live status bits (optionally
// synchronised into the clk domain) and a masked, registered interrupt request.
// Sticky/edge-history state advances only on clock-enable pulses; the
// synchroniser and irq register run on every clk edge.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   en       in   1-clk-wide clock-enable pulse (slow-clock edge)
//   evtIn    in   [NEVT]  event strobes/levels
//   liveIn   in   [NLIVE] live status inputs
//   clrAll   in   clear-all strobe (SKRES write)
//   clrBits  in   [NEVT]  write-1-to-clear mask, qualified by clrWr
//   clrWr    in   per-bit clear write strobe
//   irqMask  in   [NEVT]  interrupt enable per event bit
//   irq      out  registered interrupt request
//   Dout     out  [DW]    status read value (active-low when INVERT=1)
// -----------------------------------------------------------------------------
module skstat_gen_reg #(
  parameter int unsigned     NEVT      = 3,
  parameter int unsigned     NLIVE     = 4,
  parameter int unsigned     DW        = 8,
  parameter logic [NEVT-1:0] EDGE_MASK = 3'b111,
  parameter bit              SYNC      = 1'b1,
  parameter bit              INVERT    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [NEVT-1:0]  evtIn,
  input  logic [NLIVE-1:0] liveIn,
  input  logic             clrAll,
  input  logic [NEVT-1:0]  clrBits,
  input  logic             clrWr,
  input  logic [NEVT-1:0]  irqMask,
  output logic             irq,
  output logic [DW-1:0]    Dout
);

  // The read vector must be wide enough for sticky plus live fields.
  if (NEVT + NLIVE > DW) begin : g_width_check
    $error("skstat_gen_reg: NEVT + NLIVE must not exceed DW");
  end

  logic [NEVT-1:0]  sticky_q, sticky_d;
  logic [NEVT-1:0]  prev_q, prev_d;
  logic [NEVT-1:0]  set_req, clr_req;
  logic             irq_q, irq_d;
  logic [NLIVE-1:0] live_s;
  logic [DW-1:0]    dout_raw;

  // Live-input path: two-flop synchroniser or straight wire.
  if (SYNC) begin : g_sync
    logic [NLIVE-1:0] sync1_q, sync2_q;

    // Synchroniser stages run every clk, independent of en.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= liveIn;
        sync2_q <= sync1_q;
      end
    end

    assign live_s = sync2_q;
  end else begin : g_nosync
    assign live_s = liveIn;
  end

  // Next-state for sticky flags, edge history and irq.
  always_comb begin
    // Edge-mode bits need a fresh 0->1 transition; level-mode bits set while high.
    set_req = (evtIn & ~prev_q & EDGE_MASK) | (evtIn & ~EDGE_MASK);
    clr_req = {NEVT{clrAll}} | ({NEVT{clrWr}} & clrBits);
    if (en) begin
      prev_d   = evtIn;
      // Set has priority over a simultaneous clear so no event is lost.
      sticky_d = set_req | (sticky_q & ~clr_req);
    end else begin
      prev_d   = prev_q;
      sticky_d = sticky_q;
    end
    // Built from next-state so a mask change alone shows up on the next clk.
    irq_d = |(sticky_d & irqMask);
  end

  // State registers; reset overrides any pending set on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_q <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      prev_q   <= prev_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  // Read vector: sticky in the top bits, live bits below, zero padding at the bottom.
  always_comb begin
    dout_raw                      = '0;
    dout_raw[DW-1 -: NEVT]        = sticky_q;
    dout_raw[DW-1-NEVT -: NLIVE]  = live_s;
    if (INVERT) begin
      Dout = ~dout_raw;
    end else begin
      Dout = dout_raw;
    end
  end

endmodule
